gpio_key_debounce: RTL and testbench

Input-side counterpart of the MCU GPIO LED output path. Takes a raw, asynchronous push-button or switch pad, synchronises it into the clk25 domain, and debounces it with a four-state FSM. It then presents a clean level, single-cycle press/release pulses, a sticky event flag with acknowledge, and a press counter to the MCU gpio input / fabric logic. Sits beside the LED counter in the FPGA top, between the board pad and the AL_MCU gpio input.

---
 rtl/gpio_key_debounce.sv | 183 ++++++++++++++++++
 tb/tb_gpio_key_debounce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_key_debounce.sv
// ---------------------------------------------------------------------------
// gpio_key_debounce
//
// Brings a raw push-button / switch pad into the clk25 domain and debounces
// it. The result goes to the MCU gpio input and to fabric logic.
//
// Processing chain:
//   pad -> 2-flop synchroniser -> polarity normalisation (raw, 1 = pressed)
//       -> 4-state debounce FSM -> registered level / press / release
//       -> sticky event flag, press counter and overflow flag
//
// Ports:
//   clk25        in   system clock, rising edge
//   fpga_rst_n   in   asynchronous active-low reset
//   key_in       in   raw pad, asynchronous and bouncy
//   evt_ack      in   single-cycle acknowledge; clears evt_pending / overflow
//   key_level    out  debounced level, 1 = pressed
//   key_press    out  one-cycle pulse on an accepted press
//   key_release  out  one-cycle pulse on an accepted release
//   evt_pending  out  sticky, set by key_press, cleared by evt_ack
//   press_cnt    out  number of accepted presses, wraps
//   overflow     out  sticky, set when press_cnt wraps, cleared by evt_ack
// ---------------------------------------------------------------------------
module gpio_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int ACTIVE_LOW      = 1,
  parameter int EVT_CNT_W       = 8
) (
  input  logic                 clk25,
  input  logic                 fpga_rst_n,
  input  logic                 key_in,
  input  logic                 evt_ack,
  output logic                 key_level,
  output logic                 key_press,
  output logic                 key_release,
  output logic                 evt_pending,
  output logic [EVT_CNT_W-1:0] press_cnt,
  output logic                 overflow
);

  // Pad level meaning "not pressed"; the synchroniser resets to it so that
  // reset release does not look like a press.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  // Qualification ends when the counter shows DEBOUNCE_CYCLES-2: the sample
  // that moved the FSM out of its stable state counts as the first one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic                 sync1_q, sync2_q;
  logic                 raw;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 evt_q;
  logic [EVT_CNT_W-1:0] pcnt_q;
  logic                 ovf_q;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q ^ IDLE_LVL;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (raw) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!raw) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!raw) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (raw) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    // The level stays high while a release is still being qualified.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // ------------------------------------------------- event bookkeeping
  // Driven from the registered press pulse, so an evt_ack that arrives in
  // the cycle key_press is visible collides with the set, and the set wins.
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      evt_q  <= 1'b0;
      pcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (press_q) begin
        evt_q <= 1'b1;
      end else if (evt_ack) begin
        evt_q <= 1'b0;
      end

      if (press_q) begin
        pcnt_q <= pcnt_q + EVT_CNT_W'(1);
      end

      if (press_q && (&pcnt_q)) begin
        ovf_q <= 1'b1;
      end else if (evt_ack) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign evt_pending = evt_q;
  assign press_cnt   = pcnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_gpio_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_gpio_key_debounce
//
// Directed scenarios followed by a random pad/ack phase. Each clock cycle is
// compared against a reference model built from the debounce rules:
//   * raw seen by the debouncer at edge k is the inverted pad value
//     sampled at edge k-2
//   * the level flips after DEBOUNCE_CYCLES consecutive samples that differ
//     from it; a single sample equal to the current level restarts the count
//   * evt_pending / press_cnt / overflow react one cycle after key_press
// ---------------------------------------------------------------------------
module tb_gpio_key_debounce;

  localparam int DC    = 8;
  localparam int CW    = 4;
  localparam int EW    = 2;
  localparam int CMAX  = (1 << EW) - 1;

  logic          clk25 = 1'b0;
  logic          fpga_rst_n;
  logic          key_in;
  logic          evt_ack;
  logic          key_level;
  logic          key_press;
  logic          key_release;
  logic          evt_pending;
  logic [EW-1:0] press_cnt;
  logic          overflow;

  gpio_key_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW),
    .ACTIVE_LOW     (1),
    .EVT_CNT_W      (EW)
  ) dut (
    .clk25      (clk25),
    .fpga_rst_n (fpga_rst_n),
    .key_in     (key_in),
    .evt_ack    (evt_ack),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .evt_pending(evt_pending),
    .press_cnt  (press_cnt),
    .overflow   (overflow)
  );

  always #5 clk25 = ~clk25;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic m_h1, m_h2;   // pad sampled one and two edges ago
  logic m_level;
  int   m_run;
  logic m_press, m_rel, m_evt, m_ovf;
  int   m_cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h1 = 1'b1; m_h2 = 1'b1;
    m_level = 1'b0; m_run = 0;
    m_press = 1'b0; m_rel = 1'b0;
    m_evt = 1'b0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic p, input logic a);
    logic r;
    r = ~m_h2;
    m_h2 = m_h1;
    m_h1 = p;
    if (m_press) m_evt = 1'b1;
    else if (a)  m_evt = 1'b0;
    if (m_press && m_cnt == CMAX) m_ovf = 1'b1;
    else if (a)                   m_ovf = 1'b0;
    if (m_press) m_cnt = (m_cnt + 1) % (CMAX + 1);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (r != m_level) begin
      m_run++;
      if (m_run == DC) begin
        m_level = r;
        m_press = r;
        m_rel   = ~r;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".level"},   {7'd0, key_level},   {7'd0, m_level});
    chk({ph, ".press"},   {7'd0, key_press},   {7'd0, m_press});
    chk({ph, ".release"}, {7'd0, key_release}, {7'd0, m_rel});
    chk({ph, ".evt"},     {7'd0, evt_pending}, {7'd0, m_evt});
    chk({ph, ".cnt"},     {6'd0, press_cnt},   8'(m_cnt));
    chk({ph, ".ovf"},     {7'd0, overflow},    {7'd0, m_ovf});
  endtask

  task automatic step(input string ph, input logic p, input logic a);
    key_in  = p;
    evt_ack = a;
    @(posedge clk25);
    model_edge(p, a);
    #1;
    check_all(ph);
  endtask

  // Drive a constant pad until the selected pulse shows up; returns the
  // number of edges taken (41 if it never appears).
  task automatic wait_evt(input string ph, input logic p, input logic a_first,
                          input bit want_release, output int cycles);
    cycles = 41;
    for (int i = 1; i <= 40; i++) begin
      step(ph, p, (i == 1) ? a_first : 1'b0);
      if ((want_release ? key_release : key_press) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    key_in     = 1'b1;
    evt_ack    = 1'b0;
    fpga_rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk25);
    #1;
    fpga_rst_n = 1'b1;
    repeat (4) step("idle", 1'b1, 1'b0);

    // 1: clean press
    wait_evt("press1", 1'b0, 1'b0, 1'b0, cyc);
    chk("press1.latency", 8'(cyc), 8'd10);
    chk("press1.level", {7'd0, key_level}, 8'd1);
    step("press1", 1'b0, 1'b0);
    chk("press1.evt", {7'd0, evt_pending}, 8'd1);
    chk("press1.cnt", {6'd0, press_cnt}, 8'd1);

    // 3: release with ack
    wait_evt("rel1", 1'b1, 1'b1, 1'b1, cyc);
    chk("rel1.latency", 8'(cyc), 8'd10);
    chk("rel1.level", {7'd0, key_level}, 8'd0);
    chk("rel1.evt", {7'd0, evt_pending}, 8'd0);
    chk("rel1.cnt", {6'd0, press_cnt}, 8'd1);
    step("rel1", 1'b1, 1'b0);

    // 2: bounce rejection
    repeat (5) step("bounce", 1'b0, 1'b0);
    step("bounce", 1'b1, 1'b0);
    wait_evt("bounce", 1'b0, 1'b0, 1'b0, cyc);
    chk("bounce.latency", 8'(cyc), 8'd10);
    step("bounce", 1'b0, 1'b0);
    chk("bounce.cnt", {6'd0, press_cnt}, 8'd2);

    // 4: ack colliding with key_press
    wait_evt("coll", 1'b1, 1'b1, 1'b1, cyc);
    wait_evt("coll", 1'b0, 1'b0, 1'b0, cyc);
    step("coll", 1'b0, 1'b1);
    chk("coll.evt_set_wins", {7'd0, evt_pending}, 8'd1);
    step("coll", 1'b0, 1'b1);
    chk("coll.evt_cleared", {7'd0, evt_pending}, 8'd0);
    chk("coll.cnt", {6'd0, press_cnt}, 8'd3);

    // 5: wrap of the press counter
    wait_evt("wrap", 1'b1, 1'b0, 1'b1, cyc);
    wait_evt("wrap", 1'b0, 1'b0, 1'b0, cyc);
    step("wrap", 1'b0, 1'b0);
    chk("wrap.cnt", {6'd0, press_cnt}, 8'd0);
    chk("wrap.ovf", {7'd0, overflow}, 8'd1);
    step("wrap", 1'b0, 1'b1);
    chk("wrap.ovf_cleared", {7'd0, overflow}, 8'd0);
    chk("wrap.cnt_kept", {6'd0, press_cnt}, 8'd0);

    // 6: reset in the middle of press qualification
    wait_evt("mid", 1'b1, 1'b0, 1'b1, cyc);
    repeat (8) step("mid", 1'b0, 1'b0);
    fpga_rst_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    repeat (3) begin
      @(posedge clk25);
      #1;
      check_all("midrst");
    end
    fpga_rst_n = 1'b1;
    wait_evt("mid", 1'b0, 1'b0, 1'b0, cyc);
    chk("mid.latency", 8'(cyc), 8'd10);
    step("mid", 1'b0, 1'b0);
    chk("mid.cnt", {6'd0, press_cnt}, 8'd1);

    // random pad runs with sporadic acknowledges
    for (int r = 0; r < 220; r++) begin
      logic p;
      int   len;
      p   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++)
        step("rand", p, ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
